boron_decrypt_sequencer: RTL and testbench
==========================================

Name: boron_decrypt_sequencer

Overview:
- Iterative round controller for the BORON 64-bit block decryption path.
- Accepts one ciphertext per valid/ready handshake and applies the initial whitening key.
- Drives the external combinational inverse-round datapath once per clock, NROUNDS times, XORing a round key after each round.
- Returns the plaintext on a valid/ready output handshake. Sits between the key-schedule store (round-key lookup) and the inverse-round datapath (inverse XOR mix, inverse rotations, inverse S-box).

Parameters:
- NROUNDS, 25, number of inverse rounds after whitening; round-key indices run NROUNDS down to 0.
- IDXW, 5, width of the round-key index; must satisfy 2^IDXW > NROUNDS.

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  ciphertext valid.
- in_ready_o  output  1  block can accept ciphertext.
- in_data_i  input  64  ciphertext.
- rk_idx_o  output  IDXW  round-key index requested this cycle.
- rk_i  input  64  round key for rk_idx_o, combinational same-cycle return.
- dp_data_o  output  64  state presented to the inverse-round datapath.
- dp_data_i  input  64  inverse-round result for dp_data_o, combinational.
- out_valid_o  output  1  plaintext valid.
- out_ready_i  input  1  downstream accepts plaintext.
- out_data_o  output  64  plaintext.
- busy_o  output  1  high in RUN.
- round_o  output  IDXW  current round counter, for debug.

Behaviour:
- Reset is asynchronous, active-low: clk_i single clock, rst_ni. On assertion, immediately:
  - FSM goes to IDLE, state register = 0, round counter = 0.
  - Outputs: in_ready_o=1 once in IDLE, out_valid_o=0, busy_o=0, out_data_o=0, dp_data_o=0.
  - Reset mid-RUN or mid-DONE discards the block with no output.
- Registers: 64-bit state (out_data_o and dp_data_o both equal state), IDXW-bit counter r, 2-bit FSM.
- IDLE:
  - in_ready_o=1, rk_idx_o=NROUNDS.
  - On in_valid_i & in_ready_o: state <= in_data_i ^ rk_i (whitening), r <= NROUNDS-1, go to RUN.
- RUN:
  - in_ready_o=0, busy_o=1, rk_idx_o=r.
  - Each clock: state <= dp_data_i ^ rk_i.
  - If r==0, go to DONE; else r <= r-1.
  - Exactly NROUNDS cycles in RUN; in_valid_i is ignored.
- DONE:
  - out_valid_o=1, out_data_o stable, rk_idx_o=0.
  - On out_ready_i: go to IDLE; out_valid_o drops the next cycle.
  - out_valid_o must not drop without out_ready_i.
- Latency: handshake edge T0; out_valid_o is high in the cycle after edge T0+NROUNDS (NROUNDS+1 cycles from accept to first valid).
- Throughput: one block per NROUNDS+2 cycles with out_ready_i held high. No overlap: a new input is accepted only in IDLE, one cycle after output acceptance.
- Arithmetic: all XORs are 64-bit bitwise. The counter never wraps; the decrement only occurs while r>0.
- rk_idx_o and dp_data_o are pure functions of registered state, with no combinational path from in_*/out_ready_i.
- Simultaneous events:
  - in_valid_i asserted during DONE is held off (in_ready_o=0).
  - out_ready_i high before out_valid_o has no effect.

Test Plan:
- Reset: pulse rst_ni low asynchronously between edges -> outputs reach reset values without a clock edge; in_ready_o=1 after release.
- Single block, bench datapath = identity (dp_data_i = dp_data_o), rk_i = {59'b0, rk_idx_o}:
  - in_data_i = 64'h0123_4567_89AB_CDEF -> out_data_o = 64'h0123_4567_89AB_CDEE (XOR of 0..25 = 1).
  - out_valid_o first high 26 cycles after the accept edge.
  - rk_idx_o sequence is 25, 24, ..., 0.
- Real datapath: bench instantiates the team's inverse round and key schedule with known BORON test vector key/ciphertext -> out_data_o equals the reference plaintext.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> out_valid_o and out_data_o stable, in_ready_o=0, input offered meanwhile is not accepted; release -> next block is accepted one cycle later.
- Back-to-back: in_valid_i and out_ready_i tied high with 3 blocks -> accepts spaced exactly 27 cycles apart; outputs correct and in order.
- Reset mid-RUN at r=12 -> no out_valid_o pulse; the following block decrypts correctly.

Source files
------------

// File: rtl/boron_decrypt_sequencer.sv
// Iterative round controller for the BORON 64-bit block decryption path.
// Whitens the accepted ciphertext, then steps the external inverse-round datapath NROUNDS times.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for ciphertext; rk_idx_o presents the whitening key
// ST_RUN  | one inverse round per clock; r_round counts down to 0
// ST_DONE | plaintext held on out_data_o until out_ready_i
module boron_decrypt_sequencer #(
  parameter int NROUNDS = 25,
  parameter int IDXW    = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [63:0]     in_data_i,
  output logic [IDXW-1:0] rk_idx_o,
  input  logic [63:0]     rk_i,
  output logic [63:0]     dp_data_o,
  input  logic [63:0]     dp_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [63:0]     out_data_o,
  output logic            busy_o,
  output logic [IDXW-1:0] round_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_fsm;
  state_t          w_fsm_nxt;
  logic [63:0]     r_state;
  logic [63:0]     w_state_nxt;
  logic [IDXW-1:0] r_round;
  logic [IDXW-1:0] w_round_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_round <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Handshake and key-index outputs depend only on the registered FSM/counter.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    rk_idx_o    = '0;
    case (r_fsm)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        rk_idx_o   = IDXW'(NROUNDS);
        if (in_valid_i) begin
          w_state_nxt = in_data_i ^ rk_i;
          w_round_nxt = IDXW'(NROUNDS - 1);
          w_fsm_nxt   = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o      = 1'b1;
        rk_idx_o    = r_round;
        w_state_nxt = dp_data_i ^ rk_i;
        // Counter parks at zero on the final round rather than wrapping.
        if (r_round == '0) begin
          w_fsm_nxt = ST_DONE;
        end else begin
          w_round_nxt = r_round - IDXW'(1);
        end
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  assign dp_data_o  = r_state;
  assign out_data_o = r_state;
  assign round_o    = r_round;

endmodule

// File: tb/tb_boron_decrypt_sequencer.sv
// Self-checking bench for boron_decrypt_sequencer: random ciphertexts checked against a
// loop-based decryption model using either an identity or a bench-defined inverse round.
module tb_boron_decrypt_sequencer;
  localparam int NROUNDS = 25;
  localparam int IDXW    = 5;

  logic            clk_i       = 1'b0;
  logic            rst_ni      = 1'b0;
  logic            in_valid_i  = 1'b0;
  logic            out_ready_i = 1'b0;
  logic [63:0]     in_data_i   = '0;
  logic [63:0]     rk_i;
  logic [63:0]     dp_data_i;
  logic [63:0]     dp_data_o;
  logic [63:0]     out_data_o;
  logic            in_ready_o;
  logic            out_valid_o;
  logic            busy_o;
  logic [IDXW-1:0] rk_idx_o;
  logic [IDXW-1:0] round_o;

  int errors = 0;
  int checks = 0;
  bit real_dp = 1'b0;
  logic [63:0] key_tab [0:31];
  int rk_log [$];

  boron_decrypt_sequencer #(.NROUNDS(NROUNDS), .IDXW(IDXW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .rk_idx_o(rk_idx_o), .rk_i(rk_i),
    .dp_data_o(dp_data_o), .dp_data_i(dp_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .round_o(round_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] inv_round(input logic [63:0] x);
    logic [63:0] r13;
    logic [63:0] r1;
    r13 = {x[50:0], x[63:51]};
    r1  = {x[62:0], x[63]};
    return r13 ^ (x & r1) ^ 64'h9E37_79B9_7F4A_7C15;
  endfunction

  function automatic logic [63:0] round_key(input int idx, input bit use_tab);
    if (use_tab) return key_tab[idx];
    return 64'(idx);
  endfunction

  function automatic logic [63:0] ref_decrypt(input logic [63:0] ct, input bit use_tab);
    logic [63:0] s;
    s = ct ^ round_key(NROUNDS, use_tab);
    for (int i = NROUNDS - 1; i >= 0; i--) begin
      s = (use_tab ? inv_round(s) : s) ^ round_key(i, use_tab);
    end
    return s;
  endfunction

  // Key store and inverse-round datapath as combinational bench models.
  always_comb begin
    rk_i      = real_dp ? key_tab[rk_idx_o] : {59'b0, rk_idx_o};
    dp_data_i = real_dp ? inv_round(dp_data_o) : dp_data_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_block(input logic [63:0] ct, output logic [63:0] pt,
                           output int lat, output bit timed_out);
    int n;
    rk_log.delete();
    timed_out  = 1'b0;
    in_data_i  = ct;
    in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready_o) timed_out = 1'b1;
    rk_log.push_back(int'(rk_idx_o));
    tick();
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 100) begin
      if (busy_o) rk_log.push_back(int'(rk_idx_o));
      tick();
      n++;
    end
    if (!out_valid_o) timed_out = 1'b1;
    lat = n + 1;
    pt  = out_data_o;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (out_data_o !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data_o); end
    checks++; if (round_o !== '0) begin errors++; $display("FAIL reset_round: got %0d want 0", round_o); end
    #10;
    rst_ni = 1'b1;
    tick();
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready_o); end
    // Asynchronous pulse in the middle of RUN, fully between clock edges.
    real_dp    = 1'b0;
    in_data_i  = {$urandom, $urandom};
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    repeat (3) tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL run_before_pulse: busy got %b want 1", busy_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL async_in_ready: got %b want 1", in_ready_o); end
    checks++; if (dp_data_o !== 64'h0) begin errors++; $display("FAIL async_dp_data: got %h want 0", dp_data_o); end
    checks++; if (round_o !== '0) begin errors++; $display("FAIL async_round: got %0d want 0", round_o); end
    #1;
    rst_ni = 1'b1;
    tick();
    checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL after_pulse: in_ready=%b out_valid=%b want 1/0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_single();
    logic [63:0] pt;
    logic [63:0] ct;
    int lat;
    bit to;
    int bad;
    real_dp = 1'b0;
    run_block(64'h0123_4567_89AB_CDEF, pt, lat, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout: got timeout want none"); end
    checks++; if (pt !== 64'h0123_4567_89AB_CDEE) begin errors++; $display("FAIL single_data: got %h want 0123456789abcdee", pt); end
    checks++; if (lat !== NROUNDS + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, NROUNDS + 1); end
    checks++; if (rk_log.size() !== NROUNDS + 1) begin errors++; $display("FAIL rk_seq_len: got %0d want %0d", rk_log.size(), NROUNDS + 1); end
    bad = 0;
    foreach (rk_log[i]) if (rk_log[i] != NROUNDS - i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rk_seq_order: got %0d wrong indices want 0", bad); end
    repeat (2) begin
      ct = {$urandom, $urandom};
      run_block(ct, pt, lat, to);
      checks++; if (pt !== ref_decrypt(ct, 1'b0)) begin errors++; $display("FAIL identity_random: got %h want %h", pt, ref_decrypt(ct, 1'b0)); end
    end
  endtask

  task automatic test_real();
    logic [63:0] pt;
    logic [63:0] ct;
    int lat;
    bit to;
    real_dp = 1'b1;
    repeat (4) begin
      ct = {$urandom, $urandom};
      run_block(ct, pt, lat, to);
      checks++; if (to || pt !== ref_decrypt(ct, 1'b1)) begin
        errors++; $display("FAIL real_dp: got %h (timeout=%b) want %h", pt, to, ref_decrypt(ct, 1'b1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ct;
    logic [63:0] ct2;
    logic [63:0] held;
    int n;
    real_dp    = 1'b1;
    ct         = {$urandom, $urandom};
    ct2        = {$urandom, $urandom};
    in_data_i  = ct;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 100) begin tick(); n++; end
    held = out_data_o;
    checks++; if (!out_valid_o || held !== ref_decrypt(ct, 1'b1)) begin
      errors++; $display("FAIL bp_data: got %h (valid=%b) want %h", held, out_valid_o, ref_decrypt(ct, 1'b1));
    end
    in_data_i  = ct2;
    in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== held || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b busy=%b want 1/%h/0/0",
                           i, out_valid_o, out_data_o, in_ready_o, busy_o, held);
      end
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid_o, in_ready_o);
    end
    tick();
    in_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_next_accept: busy got %b want 1", busy_o); end
    n = 0;
    while (!out_valid_o && n < 100) begin tick(); n++; end
    checks++; if (!out_valid_o || out_data_o !== ref_decrypt(ct2, 1'b1)) begin
      errors++; $display("FAIL bp_second: got %h (valid=%b) want %h", out_data_o, out_valid_o, ref_decrypt(ct2, 1'b1));
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] cts [3];
    int acc_cyc [3];
    int idx;
    int nout;
    int cyc;
    bit acc;
    bit oacc;
    logic [63:0] od;
    real_dp = 1'b1;
    foreach (cts[i]) cts[i] = {$urandom, $urandom};
    foreach (acc_cyc[i]) acc_cyc[i] = 0;
    idx = 0; nout = 0; cyc = 0;
    in_data_i   = cts[0];
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    while (nout < 3 && cyc < 300) begin
      acc  = in_valid_i && in_ready_o;
      oacc = out_valid_o && out_ready_i;
      od   = out_data_o;
      tick();
      cyc++;
      if (acc && idx < 3) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) in_data_i = cts[idx];
        else in_valid_i = 1'b0;
      end
      if (oacc && nout < 3) begin
        checks++; if (od !== ref_decrypt(cts[nout], 1'b1)) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h want %h", nout, od, ref_decrypt(cts[nout], 1'b1));
        end
        nout++;
      end
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    checks++; if (nout != 3) begin errors++; $display("FAIL b2b_count: got %0d outputs want 3", nout); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != NROUNDS + 2) begin
      errors++; $display("FAIL b2b_gap01: got %0d want %0d", acc_cyc[1] - acc_cyc[0], NROUNDS + 2);
    end
    checks++; if (acc_cyc[2] - acc_cyc[1] != NROUNDS + 2) begin
      errors++; $display("FAIL b2b_gap12: got %0d want %0d", acc_cyc[2] - acc_cyc[1], NROUNDS + 2);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    logic [63:0] pt;
    logic [63:0] ct;
    int lat;
    int n;
    int pulses;
    bit to;
    real_dp    = 1'b1;
    in_data_i  = {$urandom, $urandom};
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    n = 0;
    while (round_o !== 5'd12 && n < 100) begin tick(); n++; end
    checks++; if (round_o !== 5'd12 || busy_o !== 1'b1) begin
      errors++; $display("FAIL midrun_reach: round=%0d busy=%b want 12/1", round_o, busy_o);
    end
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    pulses = 0;
    repeat (40) begin
      tick();
      if (out_valid_o) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrun_no_output: got %0d valid cycles want 0", pulses); end
    ct = {$urandom, $urandom};
    run_block(ct, pt, lat, to);
    checks++; if (to || pt !== ref_decrypt(ct, 1'b1)) begin
      errors++; $display("FAIL midrun_next_block: got %h (timeout=%b) want %h", pt, to, ref_decrypt(ct, 1'b1));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) key_tab[i] = {$urandom, $urandom};
    test_reset();
    test_single();
    test_real();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
